// File: rtl/sdf_fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdf_fft_pkg
// Description : Shared types and constants for the 64-point radix-2 SDF FFT
//               sequencer: FSM state encoding, default transform size and
//               frame position constants.
// Revision    : 1.0 - initial release
// ============================================================================
package sdf_fft_pkg;

    // Default log2 of the FFT size (stage count and select width).
    localparam int N_LOG2_DEF = 6;

    // Position of the last sample in a frame.
    localparam int LAST_IDX  = (1 << N_LOG2_DEF) - 1;

    // Counter value on the final flush advance. The pipeline latency is one
    // frame minus one advance, so the last real bin appears one position
    // early.
    localparam int FLUSH_END = LAST_IDX - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    // Last frame index for an arbitrary transform size.
    function automatic int last_idx(input int n_log2);
        return (1 << n_log2) - 1;
    endfunction

endpackage : sdf_fft_pkg
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter
// Description : Free-wrapping binary counter with count enable and a
//               synchronous clear that takes priority over the enable.
// Ports       : clk, rst_n  - clock, asynchronous active-low reset
//               en          - increment (modulo 2^WIDTH) this cycle
//               clr         - load zero this cycle
//               count       - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module mod_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : mod_counter
`default_nettype wire

// File: rtl/sdf_fft_controller.sv
`default_nettype none
// ============================================================================
// Module      : sdf_fft_controller
// Description : Sequencer for a radix-2 single-path delay-feedback FFT.
//               Tracks the sample position within a frame, drives the
//               per-stage butterfly/bypass selects and the delay-line
//               advance strobe, injects zeros to flush the pipeline after
//               the final frame and frames the output stream.
// Ports       : clk, rst_n   - clock, asynchronous active-low reset
//               en           - global enable (0 freezes everything)
//               in_valid     - source has a sample
//               in_ready     - sample accepted when valid (low in flush)
//               in_sof       - first sample of a frame
//               in_eos       - last sample of the final frame
//               adv          - advance strobe to delay lines / stages
//               sel          - sel[k] is the stage-k mux select
//               zero_in      - substitute a zero sample for the source
//               out_valid    - last-stage output valid
//               out_sof      - output is bin 0
//               out_last     - output is bin 63 of the final frame
//               err_sof      - one-cycle pulse after a framing violation
// Revision    : 1.0 - initial release
// ============================================================================
module sdf_fft_controller
    import sdf_fft_pkg::*;
#(
    parameter int N_LOG2 = N_LOG2_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic              in_eos,
    output logic              adv,
    output logic [N_LOG2-1:0] sel,
    output logic              zero_in,
    output logic              out_valid,
    output logic              out_sof,
    output logic              out_last,
    output logic              err_sof
);

    localparam logic [N_LOG2-1:0] c_last_idx  = N_LOG2'(last_idx(N_LOG2));
    localparam logic [N_LOG2-1:0] c_flush_end = c_last_idx - 1'b1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_LOG2-1:0] w_cnt;
    logic              w_acc;
    logic              w_adv;
    logic              w_clr;
    logic              w_err;
    logic              w_out_valid;
    logic              w_out_sof;
    logic              w_out_last;
    logic              w_at_last;
    logic              w_at_zero;
    logic              w_at_fend;
    logic              r_err_sof;

    assign in_ready  = (r_state != ST_FLUSH);
    assign w_acc     = en & in_valid & in_ready;
    assign w_at_last = (w_cnt == c_last_idx);
    assign w_at_zero = (w_cnt == '0);
    assign w_at_fend = (w_cnt == c_flush_end);

    // ------------------------------------------------------------------
    // State register and registered framing-error pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_err_sof <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_err_sof <= w_err;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and strobe decode. Every output is gated by an accept
    // (or by en in flush), so en=0 naturally freezes the sequencer.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        w_clr       = 1'b0;
        w_err       = 1'b0;
        w_out_valid = 1'b0;
        w_out_sof   = 1'b0;
        w_out_last  = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    if (in_sof) begin
                        w_adv       = 1'b1;
                        w_state_nxt = ST_FILL;
                    end else begin
                        // Stray sample outside a frame is dropped.
                        w_err = 1'b1;
                    end
                end
            end

            ST_FILL: begin
                if (w_acc) begin
                    w_adv = 1'b1;
                    // Only bin 0 of the first frame emerges while filling.
                    w_out_valid = w_at_last;
                    w_out_sof   = w_at_last;
                    if (w_at_last) begin
                        w_state_nxt = in_eos ? ST_FLUSH : ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (w_acc) begin
                    w_adv       = 1'b1;
                    w_out_valid = 1'b1;
                    w_out_sof   = w_at_last;
                    if (w_at_last && in_eos) begin
                        w_state_nxt = ST_FLUSH;
                    end
                    // Misplaced framing flags are reported but the sample
                    // keeps its counter position.
                    if (in_eos && !w_at_last) begin
                        w_err = 1'b1;
                    end
                    if (in_sof != w_at_zero) begin
                        w_err = 1'b1;
                    end
                end
            end

            ST_FLUSH: begin
                if (en) begin
                    w_adv       = 1'b1;
                    w_out_valid = 1'b1;
                    w_out_sof   = w_at_last;
                    if (w_at_fend) begin
                        w_out_last  = 1'b1;
                        w_clr       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Frame position counter
    // ------------------------------------------------------------------
    mod_counter #(
        .WIDTH (N_LOG2)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_adv),
        .clr   (w_clr),
        .count (w_cnt)
    );

    // Stage k toggles every 2^(N_LOG2-1-k) advances: the first stage uses
    // the counter MSB, the last stage the LSB.
    for (genvar k = 0; k < N_LOG2; k++) begin : g_sel
        assign sel[k] = w_cnt[N_LOG2-1-k];
    end

    assign adv       = w_adv;
    assign zero_in   = (r_state == ST_FLUSH);
    assign out_valid = w_out_valid;
    assign out_sof   = w_out_sof;
    assign out_last  = w_out_last;
    assign err_sof   = r_err_sof;

endmodule : sdf_fft_controller
`default_nettype wire

// File: tb/tb_sdf_fft_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdf_fft_controller
// Description : Directed self-checking bench for sdf_fft_controller. Each
//               accepted sample is pushed into a 63-deep delay model; the
//               entry leaving the model on an advance gives the expected
//               output framing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdf_fft_controller;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       in_valid;
    logic       in_ready;
    logic       in_sof;
    logic       in_eos;
    logic       adv;
    logic [5:0] sel;
    logic       zero_in;
    logic       out_valid;
    logic       out_sof;
    logic       out_last;
    logic       err_sof;

    sdf_fft_controller #(
        .N_LOG2 (6)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_eos    (in_eos),
        .adv       (adv),
        .sel       (sel),
        .zero_in   (zero_in),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_last  (out_last),
        .err_sof   (err_sof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_real;
        logic       last;
        logic [5:0] idx;
    } ent_t;

    ent_t q[$];
    int   total;
    int   bad;
    int   pos;
    logic exp_err;
    int   ov_cnt;
    int   sof_cnt;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [5:0] rev6(input int p);
        logic [5:0] r;
        for (int k = 0; k < 6; k++) r[k] = p[5-k];
        return r;
    endfunction

    // One clock cycle: drive inputs, check at the falling edge, then step to
    // just after the next rising edge.
    task automatic cyc(input logic v, input logic s, input logic e, input logic en_i,
                       input logic exp_adv, input logic fl, input logic viol,
                       input logic lst);
        ent_t f;
        ent_t n;
        logic ev;
        logic es;
        logic el;
        logic [5:0] exp_sel;
        in_valid = v;
        in_sof   = s;
        in_eos   = e;
        en       = en_i;
        @(negedge clk);
        exp_sel = rev6(pos);
        ev = 1'b0;
        es = 1'b0;
        el = 1'b0;
        if (exp_adv) begin
            if (q.size() == 63) begin
                f  = q.pop_front();
                ev = f.is_real;
                es = f.is_real && (f.idx == 6'd0);
                el = f.last;
            end
            n.is_real = ~fl;
            n.last    = lst;
            n.idx     = 6'(pos);
            q.push_back(n);
            pos = (pos + 1) % 64;
        end
        chk("adv",       {7'd0, adv},       {7'd0, exp_adv});
        chk("sel",       {2'd0, sel},       {2'd0, exp_sel});
        chk("in_ready",  {7'd0, in_ready},  {7'd0, ~fl});
        chk("zero_in",   {7'd0, zero_in},   {7'd0, fl});
        chk("out_valid", {7'd0, out_valid}, {7'd0, ev});
        chk("out_sof",   {7'd0, out_sof},   {7'd0, es});
        chk("out_last",  {7'd0, out_last},  {7'd0, el});
        chk("err_sof",   {7'd0, err_sof},   {7'd0, exp_err});
        if (out_valid === 1'b1) ov_cnt++;
        if (out_sof === 1'b1) sof_cnt++;
        if (el) begin
            q.delete();
            pos = 0;
        end
        exp_err = viol;
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic s, input logic e, input logic viol, input logic lst);
        cyc(1'b1, s, e, 1'b1, 1'b1, 1'b0, viol, lst);
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic flush_cyc();
        // in_valid held high to show the source is ignored during flush.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int c;
        int i;
        total    = 0;
        bad      = 0;
        pos      = 0;
        exp_err  = 1'b0;
        ov_cnt   = 0;
        sof_cnt  = 0;
        rst_n    = 1'b0;
        en       = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eos   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
        chk("rst_adv",      {7'd0, adv},      8'd0);
        chk("rst_sel",      {2'd0, sel},      8'd0);
        chk("rst_err",      {7'd0, err_sof},  8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Stray sample in IDLE: dropped, error pulse next cycle
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_cyc();
        idle_cyc();

        // Single frame followed by flush
        for (int k = 0; k < 64; k++) sample(k == 0, k == 63, 1'b0, k == 63);
        ov_cnt = 0;
        for (int k = 0; k < 63; k++) flush_cyc();
        chk("flush_ov_cnt", 8'(ov_cnt), 8'd63);
        idle_cyc();

        // Three frames with source gaps, flush frozen for 5 cycles at 40
        ov_cnt  = 0;
        sof_cnt = 0;
        c       = 0;
        for (int f = 0; f < 3; f++) begin
            i = 0;
            while (i < 64) begin
                c++;
                if (c % 3 == 0) begin
                    idle_cyc();
                end else begin
                    sample(i == 0, (f == 2) && (i == 63), 1'b0, (f == 2) && (i == 63));
                    i++;
                end
            end
        end
        for (int k = 0; k < 63; k++) begin
            if (k == 40) begin
                repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            end
            flush_cyc();
        end
        chk("gap_ov_cnt",  8'(ov_cnt),  8'd192);
        chk("gap_sof_cnt", 8'(sof_cnt), 8'd3);
        idle_cyc();

        // Framing errors in RUN: SOF at 10, EOS at 20
        for (int k = 0; k < 64; k++) sample(k == 0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 64; k++) sample((k == 0) || (k == 10), k == 20,
                                            (k == 10) || (k == 20), 1'b0);
        for (int k = 0; k < 17; k++) sample(k == 0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset at position 17 in RUN, away from any edge
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_adv",       {7'd0, adv},       8'd0);
        chk("arst_sel",       {2'd0, sel},       8'd0);
        chk("arst_out_valid", {7'd0, out_valid}, 8'd0);
        chk("arst_in_ready",  {7'd0, in_ready},  8'd1);
        chk("arst_err",       {7'd0, err_sof},   8'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        pos     = 0;
        exp_err = 1'b0;

        // Restart cleanly after reset
        for (int k = 0; k < 4; k++) sample(k == 0, 1'b0, 1'b0, 1'b0);
        idle_cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sdf_fft_controller
`default_nettype wire
